// File: rtl/csr_access_arbiter_pkg.sv
// Shared types for the CSR access arbiter: address/data words, the arbiter
// state encoding, requester indices and the latched command record.
package csr_arb_pkg;

    typedef logic [11:0] csr_addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

    localparam req_idx_t REQ_PIPE = 1'b0;
    localparam req_idx_t REQ_DBG  = 1'b1;

    typedef struct packed {
        logic      swap;
        logic      clr;
        logic      set;
        csr_addr_t addr;
        word_t     wdata;
    } csr_cmd_t;

    // More than one op bit set cannot be expressed as a single CSR command.
    function automatic logic csr_op_illegal(input logic swap, input logic clr, input logic set);
        return (swap & clr) | (swap & set) | (clr & set);
    endfunction

endpackage

// File: rtl/csr_access_arbiter_if.sv
// Single-cycle command port into the CSR register file. The arbiter drives
// it through the pipe modport; the register file sits on the csr modport and
// answers combinationally in the same cycle.
interface csr_pipe_if;
    import csr_arb_pkg::*;

    logic      csr_swap;
    logic      csr_clr;
    logic      csr_set;
    csr_addr_t csr_addr;
    word_t     csr_wdata;
    word_t     csr_rdata;
    logic      csr_invalid;

    modport pipe (
        output csr_swap, csr_clr, csr_set, csr_addr, csr_wdata,
        input  csr_rdata, csr_invalid
    );

    modport csr (
        input  csr_swap, csr_clr, csr_set, csr_addr, csr_wdata,
        output csr_rdata, csr_invalid
    );

endinterface

// File: rtl/csr_access_arbiter_priority_sel.sv
// Combinational winner select for the CSR arbiter: the pipeline beats debug.
// With CSR_ARB_STARVE_GUARD_EN defined, debug wins once the pipeline has
// taken STARVE_LIMIT consecutive grants while debug was waiting.
module csr_arb_priority_sel
    import csr_arb_pkg::*;
`ifdef CSR_ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
)
`endif
(
    input  logic [1:0]       req,
`ifdef CSR_ARB_STARVE_GUARD_EN
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_vld,
    output req_idx_t         grant_idx
);

    // Fixed priority, optionally overridden in favour of a starved debug request
    always_comb begin
        grant_vld = req[REQ_PIPE] | req[REQ_DBG];
        grant_idx = req[REQ_PIPE] ? REQ_PIPE : REQ_DBG;
`ifdef CSR_ARB_STARVE_GUARD_EN
        if (req[REQ_PIPE] && req[REQ_DBG] && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            grant_idx = REQ_DBG;
        end
`endif
    end

endmodule

// File: rtl/csr_access_arbiter.sv
// CSR access arbiter: shares the CSR file port between the pipeline (0) and
// the debug module (1). Each grant runs IDLE -> ISSUE -> RESP, giving the CSR
// file exactly one single-cycle command and the winner a one-cycle ack.
// Optional feature macro: CSR_ARB_STARVE_GUARD_EN (debug starvation guard).
module csr_access_arbiter
    import csr_arb_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int STARVE_LIMIT = 8
)
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_swap,
    input  logic [NREQ-1:0]   req_clr,
    input  logic [NREQ-1:0]   req_set,
    input  logic [12*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output word_t             resp_rdata,
    output logic              resp_invalid,
    output logic              busy,
    csr_pipe_if.pipe          csr_bus
);

    if (NREQ != 2 || STARVE_LIMIT < 1) begin : g_cfg_err
        $error("csr_access_arbiter: NREQ must be 2 and STARVE_LIMIT at least 1");
    end

    arb_state_e state_q;
    arb_state_e state_d;

    logic       grant_vld;
    req_idx_t   grant_idx;
    csr_cmd_t   sel_cmd;

    csr_cmd_t   cmd_p0;
    req_idx_t   idx_p0;
    logic       illegal_p0;
    word_t      rdata_p1;
    logic       invalid_p1;

`ifdef CSR_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;

    csr_arb_priority_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_sel (
        .req        (req),
        .starve_cnt (starve_cnt_q),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx)
    );

    // Count pipeline grants taken while debug waits; any debug grant or an
    // IDLE decision without a debug request ends the streak
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (!req[REQ_DBG] || (grant_idx == REQ_DBG)) begin
                starve_cnt_q <= '0;
            end else begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end
`else
    csr_arb_priority_sel u_sel (
        .req       (req),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );
`endif

    // Route the winning requester's op, address and data toward the command register
    always_comb begin
        sel_cmd = '0;
        if (grant_idx == REQ_DBG) begin
            sel_cmd.swap  = req_swap[1];
            sel_cmd.clr   = req_clr[1];
            sel_cmd.set   = req_set[1];
            sel_cmd.addr  = req_addr[23:12];
            sel_cmd.wdata = req_wdata[63:32];
        end else begin
            sel_cmd.swap  = req_swap[0];
            sel_cmd.clr   = req_clr[0];
            sel_cmd.set   = req_set[0];
            sel_cmd.addr  = req_addr[11:0];
            sel_cmd.wdata = req_wdata[31:0];
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: ISSUE and RESP each last exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (grant_vld) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Latch the winner's command only on the IDLE decision; frozen otherwise
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cmd_p0 <= '0;
            idx_p0 <= REQ_PIPE;
        end else if (state_q == ARB_IDLE && grant_vld) begin
            cmd_p0 <= sel_cmd;
            idx_p0 <= grant_idx;
        end
    end

    assign illegal_p0 = csr_op_illegal(cmd_p0.swap, cmd_p0.clr, cmd_p0.set);

    // Capture the CSR file answer during ISSUE; illegal ops report invalid with zero data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdata_p1   <= '0;
            invalid_p1 <= 1'b0;
        end else if (state_q == ARB_ISSUE) begin
            if (illegal_p0) begin
                rdata_p1   <= '0;
                invalid_p1 <= 1'b1;
            end else begin
                rdata_p1   <= csr_bus.csr_rdata;
                invalid_p1 <= csr_bus.csr_invalid;
            end
        end
    end

    // Outputs decoded from state so reset removes strobes and ack at once
    always_comb begin
        ack                = '0;
        resp_rdata         = '0;
        resp_invalid       = 1'b0;
        busy               = (state_q != ARB_IDLE);
        csr_bus.csr_swap   = 1'b0;
        csr_bus.csr_clr    = 1'b0;
        csr_bus.csr_set    = 1'b0;
        csr_bus.csr_addr   = cmd_p0.addr;
        csr_bus.csr_wdata  = cmd_p0.wdata;
        if (state_q == ARB_ISSUE && !illegal_p0) begin
            csr_bus.csr_swap = cmd_p0.swap;
            csr_bus.csr_clr  = cmd_p0.clr;
            csr_bus.csr_set  = cmd_p0.set;
        end
        if (state_q == ARB_RESP) begin
            ack[idx_p0]  = 1'b1;
            resp_rdata   = rdata_p1;
            resp_invalid = invalid_p1;
        end
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Randomized bench for csr_access_arbiter with a transaction-level model:
// each grant is predicted from the arbitration rules, then the issue cycle
// and ack cycle that follow it are checked against the predicted command.
module tb_csr_access_arbiter;
    import csr_arb_pkg::*;

    localparam int LIMIT   = 2;
    localparam int NCYC    = 3000;
    localparam int P2_FROM = 20;
    localparam int P2_TO   = 100;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b1;
    logic [1:0]  req, req_swap, req_clr, req_set, ack;
    logic [23:0] req_addr;
    logic [63:0] req_wdata;
    word_t       resp_rdata;
    logic        resp_invalid, busy;

    csr_pipe_if bus();

    csr_access_arbiter #(.NREQ(2), .STARVE_LIMIT(LIMIT)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req          (req),
        .req_swap     (req_swap),
        .req_clr      (req_clr),
        .req_set      (req_set),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .resp_rdata   (resp_rdata),
        .resp_invalid (resp_invalid),
        .busy         (busy),
        .csr_bus      (bus)
    );

    always #5 CLK = ~CLK;

    function automatic word_t csr_file_rdata(input csr_addr_t a);
        if (a == 12'h300) return 32'h0000_1800;
        return {a[7:0], a, ~a};
    endfunction

    function automatic logic csr_file_invalid(input csr_addr_t a);
        return (a[11:8] == 4'hF);
    endfunction

    assign bus.csr_rdata   = csr_file_rdata(bus.csr_addr);
    assign bus.csr_invalid = csr_file_invalid(bus.csr_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // requester-side pending transactions
    logic      has   [2];
    logic      t_sw  [2];
    logic      t_cl  [2];
    logic      t_st  [2];
    csr_addr_t t_addr[2];
    word_t     t_wd  [2];

    // model state
    int        next_eval = 0;
    bit        inflight  = 0;
    int        g_cyc, g_idx;
    logic      g_sw, g_cl, g_st;
    csr_addr_t g_addr;
    word_t     g_wd;
    int        cnt = 0;
    int        ack_idx;
    int        p2_k = 0;
    bit        rst_done = 0;
    bit        rst_release = 0;

    task automatic new_txn(input int i);
        int r;
        r = $urandom_range(0, 7);
        has[i] = 1'b1;
        t_sw[i] = 1'b0; t_cl[i] = 1'b0; t_st[i] = 1'b0;
        case (r)
            1, 5: t_sw[i] = 1'b1;
            2, 6: t_cl[i] = 1'b1;
            3, 7: t_st[i] = 1'b1;
            4: begin
                t_sw[i] = 1'b1;
                t_cl[i] = 1'($urandom_range(0, 1));
                t_st[i] = ~t_cl[i] | 1'($urandom_range(0, 1));
            end
            default: ;
        endcase
        t_addr[i] = ($urandom_range(0, 5) == 0) ? {4'hF, 8'($urandom)} : 12'($urandom);
        t_wd[i]   = $urandom;
    endtask

    task automatic drive_bus();
        for (int i = 0; i < 2; i++) begin
            req[i] = has[i];
            if (has[i]) begin
                req_swap[i] = t_sw[i];
                req_clr[i]  = t_cl[i];
                req_set[i]  = t_st[i];
                req_addr[12*i +: 12] = t_addr[i];
                req_wdata[32*i +: 32] = t_wd[i];
            end else begin
                req_swap[i] = 1'($urandom);
                req_clr[i]  = 1'($urandom);
                req_set[i]  = 1'($urandom);
                req_addr[12*i +: 12] = 12'($urandom);
                req_wdata[32*i +: 32] = $urandom;
            end
        end
    endtask

    // one arbitration decision by the rules: pipeline first, starved debug overrides
    task automatic evaluate(input int c);
        int w;
        if (!has[0] && !has[1]) begin
            cnt = 0;
            next_eval = c + 1;
            return;
        end
        w = has[0] ? 0 : 1;
`ifdef CSR_ARB_STARVE_GUARD_EN
        if (has[0] && has[1] && cnt == LIMIT) w = 1;
`endif
        if (!has[1] || w == 1) cnt = 0;
        else cnt++;
        inflight = 1;
        g_cyc = c; g_idx = w;
        g_sw = t_sw[w]; g_cl = t_cl[w]; g_st = t_st[w];
        g_addr = t_addr[w]; g_wd = t_wd[w];
        next_eval = c + 3;
    endtask

    task automatic check_outputs(input int c);
        logic [1:0] exp_ack;
        logic [2:0] exp_str;
        logic       exp_busy;
        bit         legal;
        exp_ack = 2'b00; exp_str = 3'b000; exp_busy = 1'b0;
        ack_idx = -1;
        legal = (int'(g_sw) + int'(g_cl) + int'(g_st)) <= 1;
        if (inflight && c == g_cyc) begin
            exp_busy = 1'b1;
            exp_str = legal ? {g_sw, g_cl, g_st} : 3'b000;
            chk("issue_addr", 64'(bus.csr_addr), 64'(g_addr));
            chk("issue_wdata", 64'(bus.csr_wdata), 64'(g_wd));
        end else if (inflight && c == g_cyc + 1) begin
            exp_busy = 1'b1;
            exp_ack[g_idx] = 1'b1;
            chk("resp_rdata", 64'(resp_rdata), legal ? 64'(csr_file_rdata(g_addr)) : 64'd0);
            chk("resp_invalid", 64'(resp_invalid), legal ? 64'(csr_file_invalid(g_addr)) : 64'd1);
            if (g_cyc >= P2_FROM && g_cyc < P2_TO) begin
`ifdef CSR_ARB_STARVE_GUARD_EN
                chk("hold_order", 64'(ack), (p2_k % (LIMIT + 1) == LIMIT) ? 64'd2 : 64'd1);
`else
                chk("hold_order", 64'(ack), 64'd1);
`endif
                p2_k++;
            end
            ack_idx = g_idx;
            inflight = 0;
        end
        chk("ack", 64'(ack), 64'(exp_ack));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("strobes", 64'({bus.csr_swap, bus.csr_clr, bus.csr_set}), 64'(exp_str));
        if (rst_release) begin
            nRST = 1'b1;
            rst_release = 0;
        end
        // drop reset in the middle of an ISSUE cycle once, during random traffic
        if (!rst_done && c >= 500 && inflight && c == g_cyc) begin
            #2 nRST = 1'b0;
            #1;
            chk("rst_strobes", 64'({bus.csr_swap, bus.csr_clr, bus.csr_set}), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ack", 64'(ack), 64'd0);
            inflight = 0;
            cnt = 0;
            next_eval = c + 2;
            rst_done = 1;
            rst_release = 1;
        end
    endtask

    task automatic stimulus(input int c);
        if (ack_idx >= 0) has[ack_idx] = 1'b0;
        if (c == 9) begin
            has[1] = 1'b1;
            t_sw[1] = 1'b1; t_cl[1] = 1'b0; t_st[1] = 1'b1;
            t_addr[1] = 12'h7C0;
            t_wd[1] = 32'hDEAD_0001;
        end else if (c >= P2_FROM - 1 && c < P2_TO) begin
            for (int i = 0; i < 2; i++) if (!has[i]) new_txn(i);
        end else if (c >= P2_TO && c < NCYC - 20) begin
            for (int i = 0; i < 2; i++) if (!has[i] && $urandom_range(0, 3) == 0) new_txn(i);
        end
        drive_bus();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            has[i] = 1'b0; t_sw[i] = 1'b0; t_cl[i] = 1'b0; t_st[i] = 1'b0;
            t_addr[i] = '0; t_wd[i] = '0;
        end
        has[0] = 1'b1; t_sw[0] = 1'b1; t_addr[0] = 12'h300; t_wd[0] = 32'h8;
        drive_bus();
        #1 nRST = 1'b0;
        #2;
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_strobes", 64'({bus.csr_swap, bus.csr_clr, bus.csr_set}), 64'd0);
        chk("reset_rdata", 64'(resp_rdata), 64'd0);
        chk("reset_invalid", 64'(resp_invalid), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge CLK);
            if (nRST && c >= next_eval) evaluate(c);
            @(negedge CLK);
            check_outputs(c);
            stimulus(c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_access_arbiter.md
Name: csr_access_arbiter

Overview:
- Shares the single CSR register-file access port between two requesters: the pipeline (index 0) and the debug module (index 1).
- Sequences each access as latch, issue, respond, so the CSR file sees exactly one single-cycle, one-hot command per grant.
- Sits between the requesters and the csr modport side of csr_pipe_if; it drives that interface as the pipe modport.

Parameters:
- NREQ, 2, number of requesters; fixed at 2 (0 = pipeline, 1 = debug).
- STARVE_LIMIT, 8, consecutive pipeline grants allowed while debug waits (used only with the optional feature).

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- req  input  2  per-requester access request; level; hold until ack.
- req_swap  input  2  per-requester swap op.
- req_clr  input  2  per-requester clear op.
- req_set  input  2  per-requester set op.
- req_addr  input  24  per-requester CSR address, 12 bits each; requester i uses [12i+11:12i].
- req_wdata  input  64  per-requester write data, 32 bits each.
- ack  output  2  one-cycle completion pulse to the granted requester.
- resp_rdata  output  32  read data; valid only while an ack bit is high.
- resp_invalid  output  1  invalid-access flag; valid only while an ack bit is high.
- busy  output  1  high in any state other than IDLE.
- csr_swap, csr_clr, csr_set  output  1 each  command strobes to the CSR file.
- csr_addr  output  12  CSR address (csr_addr_t).
- csr_wdata  output  32  CSR write data (word_t).
- csr_rdata  input  32  CSR file read data; combinational in the same cycle.
- csr_invalid  input  1  CSR file invalid flag; combinational in the same cycle.

Behaviour:
- Reset (async, nRST low):
  - State goes to IDLE.
  - ack, resp_rdata, resp_invalid, busy, csr_swap, csr_clr and csr_set all become 0; command registers clear.
  - Reset during ISSUE or RESP drops the access; strobes deassert immediately and no ack is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req bit is set, pick a winner: pipeline beats debug (fixed priority).
  - Latch the winner's op/addr/wdata and its index into command registers, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive the latched command onto the csr_* outputs.
  - Capture csr_rdata and csr_invalid into response registers, then go to RESP.
  - Strobes are 0 in every other state; csr_addr and csr_wdata hold the latched values.
- RESP (exactly one cycle):
  - ack[winner]=1; resp_* show the captured values; then go to IDLE.
- Latency: req sampled at edge N gives ack high in cycle N+2. Back-to-back accesses complete at most one per 3 cycles.
- Requester rule: req must be low at the edge ending its ack cycle, unless the requester wants a new access.
- req changes during ISSUE or RESP are ignored; command registers are frozen outside IDLE.
- Op encoding:
  - swap, clr and set all 0: read-only access; strobes stay 0 in ISSUE and rdata is still captured.
  - More than one op bit set: illegal. ISSUE drives no strobe, resp_invalid=1, resp_rdata=0.
- Simultaneous requests: the pipeline wins. Debug stays pending and is served in the next IDLE in which the pipeline does not request.

Optional Feature:
- Macro: CSR_ARB_STARVE_GUARD_EN.
- With it:
  - A counter (width = $clog2(STARVE_LIMIT+1)) counts pipeline grants made while req[1] is high.
  - When the count equals STARVE_LIMIT and both requests are high, debug wins.
  - The counter clears on any debug grant, on any IDLE evaluation with req[1] low, and on reset.
- Without it: pure fixed priority and no counter logic.

Decomposition:
- Into rv32i_types_pkg / a new csr_arb_pkg:
  - arbiter state enum (IDLE, ISSUE, RESP);
  - requester index constants REQ_PIPE=0 and REQ_DBG=1;
  - csr_cmd_t struct (swap, clr, set, csr_addr_t addr, word_t wdata).
- Reuse csr_addr_t and word_t from the existing packages.
- Sub-module csr_arb_priority_sel: combinational winner select that includes the starvation override.
- FSM, command registers and response registers stay in the top module.

Test Plan:
- Pipeline swap alone:
  - Stimulus: req=01, swap, addr 0x300, wdata 0x8; csr_rdata=0x1800.
  - Response: csr_swap high for exactly 1 cycle in ISSUE; ack=01 two cycles after sampling; resp_rdata=0x1800, resp_invalid=0.
- Simultaneous requests:
  - Stimulus: req=11 held.
  - Response: pipeline is acked first; debug is acked in the following sequence once the pipeline drops req; the two acks are separated by at least 3 cycles.
- Illegal op:
  - Stimulus: debug requests with swap=set=1.
  - Response: no csr strobe at any point; ack=10, resp_invalid=1, resp_rdata=0.
- Reset in ISSUE:
  - Stimulus: drop nRST mid-cycle during ISSUE.
  - Response: strobes go to 0 asynchronously; no ack; busy=0; the next request is processed normally.
- Starvation guard (with CSR_ARB_STARVE_GUARD_EN, STARVE_LIMIT=2):
  - Stimulus: both requests held continuously.
  - Response: grant order pipe, pipe, dbg, pipe, pipe, dbg.
- Starvation guard compiled out:
  - Stimulus: same as above.
  - Response: debug is never acked while the pipeline keeps req high.
